angle_setpoint_ctrl: RTL and testbench
======================================

Name: angle_setpoint_ctrl

Overview:
- Parametrised, clocked successor to the switch/key angle entry block.
- Holds NUM_CH saturating angle setpoints. Two debounced push-buttons step the one-hot selected channel up or down.
- A sequential binary-to-BCD converter produces three display digits for the selected channel.
- Sits between the board keys/switches and the servo PWM generators and seven-segment driver.

Parameters:
- NUM_CH, 4, number of angle channels (2..8).
- ANGLE_W, 8, setpoint width in bits (ANGLE_MAX must fit).
- ANGLE_MAX, 180, upper saturation limit (at most 999, so it fits 3 BCD digits).
- ANGLE_INIT, 90, reset value of every channel (at most ANGLE_MAX).
- DEBOUNCE_CYCLES, 50000, consecutive stable samples needed to accept a key level change (at least 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- key_up_n  in  1  increment button, active-low, asynchronous to clk.
- key_down_n  in  1  decrement button, active-low, asynchronous to clk.
- ch_sel  in  NUM_CH  one-hot channel select from the slide switches, asynchronous.
- angle_flat  out  NUM_CH*ANGLE_W  all setpoints; channel i occupies bits [i*ANGLE_W +: ANGLE_W].
- bcd_out  out  12  {hundreds, tens, units} of the selected channel.
- bcd_valid  out  1  high when bcd_out matches the current selected setpoint.
- sel_err  out  1  high while the synchronised ch_sel is not exactly one-hot.

Behaviour:
- Reset (async assert, sync release):
  - every channel = ANGLE_INIT
  - bcd_out = 0, bcd_valid = 0, sel_err = 0
  - debouncers read "released"
  - converter state = IDLE with a pending start request.
- Synchronisation: key_up_n, key_down_n and ch_sel each pass through a 2-flop synchroniser before any use.
- Debounce (per key):
  - The counter increments while the synchronised level differs from the debounced state, and clears when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced state flips and the counter clears.
  - The release-to-press transition of the debounced state emits a 1-cycle press pulse. Releases emit nothing.
- Setpoint update (the cycle after the press pulse):
  - Applies only if the synchronised ch_sel is one-hot; otherwise the press is discarded.
  - up: value = value+1, saturating at ANGLE_MAX (no wrap).
  - down: value = value-1, saturating at 0 (no wrap).
  - up and down pulses in the same cycle: no change.
  - Non-selected channels never change.
- sel_err: registered; tracks the one-hot check with 1 cycle of latency after the synchroniser.
- Converter FSM (double-dabble), states IDLE, SHIFT, DONE:
  - Trigger: any change in the selected channel's value, a change of the one-hot selection, or the reset-pending request.
  - On trigger: bcd_valid = 0, latch the operand, enter SHIFT.
  - SHIFT runs exactly ANGLE_W cycles. Each cycle adds 3 to every BCD nibble ≥5, then shifts the operand left by 1 into the BCD register.
  - DONE lasts 1 cycle: bcd_out is loaded, bcd_valid = 1, then the FSM returns to IDLE.
  - Latency from trigger to bcd_valid rising is ANGLE_W+2 cycles.
- Boundary cases:
  - A trigger during SHIFT aborts and restarts with the new operand; the latest value wins and bcd_out holds its old value.
  - While sel_err = 1, no trigger is generated; bcd_out and bcd_valid hold.
  - Reset mid-conversion returns to the reset values, with the pending request set.
  - A held key produces exactly one step; there is no auto-repeat.

Test Plan:
1. Reset, then release; ch_sel=0001 -> angle_flat shows all channels = 90; bcd_out=0x090 and bcd_valid=1 within ANGLE_W+6 cycles of release.
2. Bench DEBOUNCE_CYCLES=4. ch_sel=0100; press key_up_n 3 times, each held ≥10 cycles -> channel 2 = 93 and the other channels stay 90; bcd_out=0x093.
3. key_up_n bouncing (toggled every 2 cycles for 20 cycles, then held low) -> exactly one increment.
4. Saturation: channel 0 at 179, press up twice -> 180, 180. Channel 1 at 1, press down twice -> 0, 0. No wrap to 255.
5. ch_sel=0110, press up -> no channel changes; sel_err=1; bcd_out holds. Then ch_sel=0010 -> sel_err=0 and bcd_out refreshes to channel 1.
6. Change the selection during SHIFT (ch_sel 0001 -> 1000, channels 0 and 3 holding different values) -> bcd_valid stays 0 until the conversion completes with channel 3's value; channel 0's result never appears.

Source files
------------

// File: rtl/angle_setpoint_ctrl.sv
// angle_setpoint_ctrl
//   Holds NUM_CH saturating angle setpoints. Two debounced active-low
//   push-buttons step the channel picked by a one-hot slide-switch select
//   up or down. A sequential double-dabble converter produces three BCD
//   digits of the selected setpoint for a seven-segment driver.
//
// Ports
//   clk         system clock
//   rst         asynchronous, active-high reset (released synchronously upstream)
//   key_up_n    increment button, active-low, asynchronous to clk
//   key_down_n  decrement button, active-low, asynchronous to clk
//   ch_sel      one-hot channel select, asynchronous to clk
//   angle_flat  all setpoints, channel i at [i*ANGLE_W +: ANGLE_W]
//   bcd_out     {hundreds, tens, units} of the selected channel
//   bcd_valid   bcd_out matches the current selected setpoint
//   sel_err     synchronised ch_sel is not exactly one-hot
module angle_setpoint_ctrl #(
    parameter int NUM_CH          = 4,
    parameter int ANGLE_W         = 8,
    parameter int ANGLE_MAX       = 180,
    parameter int ANGLE_INIT      = 90,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      key_up_n,
    input  logic                      key_down_n,
    input  logic [NUM_CH-1:0]         ch_sel,
    output logic [NUM_CH*ANGLE_W-1:0] angle_flat,
    output logic [11:0]               bcd_out,
    output logic                      bcd_valid,
    output logic                      sel_err
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam int BIT_W = $clog2(ANGLE_W + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // ---------------------------------------------------------------
    // Two-flop synchronisers. Keys reset to the released (high) level.
    // Bit 0 = up key, bit 1 = down key.
    // ---------------------------------------------------------------
    logic [1:0]        key_meta_reg, key_sync_reg;
    logic [NUM_CH-1:0] sel_meta_reg, sel_sync_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_meta_reg <= 2'b11;
            key_sync_reg <= 2'b11;
            sel_meta_reg <= '0;
            sel_sync_reg <= '0;
        end else begin
            key_meta_reg <= {key_down_n, key_up_n};
            key_sync_reg <= key_meta_reg;
            sel_meta_reg <= ch_sel;
            sel_sync_reg <= sel_meta_reg;
        end
    end

    logic sel_ok;
    assign sel_ok = $onehot(sel_sync_reg);

    // ---------------------------------------------------------------
    // Debouncers: a level change is accepted after DEBOUNCE_CYCLES
    // consecutive differing samples; only release->press emits a pulse.
    // ---------------------------------------------------------------
    logic [1:0] press_pulse;

    for (genvar gi = 0; gi < 2; gi++) begin : g_debounce
        logic [CNT_W-1:0] cnt_reg;
        logic             pressed_reg;
        logic             pulse_reg;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_reg     <= '0;
                pressed_reg <= 1'b0;
                pulse_reg   <= 1'b0;
            end else begin
                pulse_reg <= 1'b0;
                if (!key_sync_reg[gi] == pressed_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    cnt_reg     <= '0;
                    pressed_reg <= !pressed_reg;
                    pulse_reg   <= !pressed_reg;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end

        assign press_pulse[gi] = pulse_reg;
    end

    logic step_up, step_down;
    assign step_up   = press_pulse[0] && !press_pulse[1];
    assign step_down = press_pulse[1] && !press_pulse[0];

    // ---------------------------------------------------------------
    // Setpoint registers and selected-channel mux.
    // ---------------------------------------------------------------
    logic [ANGLE_W-1:0] sel_terms [NUM_CH];

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_channel
        logic [ANGLE_W-1:0] angle_reg;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                angle_reg <= ANGLE_W'(ANGLE_INIT);
            end else if (sel_ok && sel_sync_reg[gi]) begin
                if (step_up && angle_reg != ANGLE_W'(ANGLE_MAX))
                    angle_reg <= angle_reg + 1'b1;
                else if (step_down && angle_reg != '0)
                    angle_reg <= angle_reg - 1'b1;
            end
        end

        assign angle_flat[gi*ANGLE_W +: ANGLE_W] = angle_reg;
        assign sel_terms[gi] = sel_sync_reg[gi] ? angle_reg : '0;
    end

    logic [ANGLE_W-1:0] sel_value;

    always_comb begin
        sel_value = '0;
        for (int i = 0; i < NUM_CH; i++)
            sel_value = sel_value | sel_terms[i];
    end

    logic sel_err_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sel_err_reg <= 1'b0;
        else     sel_err_reg <= !sel_ok;
    end

    // ---------------------------------------------------------------
    // Double-dabble converter. conv_sel/conv_val remember what the most
    // recent conversion was started for; any difference re-triggers,
    // which also aborts a conversion already in flight.
    // ---------------------------------------------------------------
    logic [1:0]         state_reg;
    logic               pending_reg;
    logic [NUM_CH-1:0]  conv_sel_reg;
    logic [ANGLE_W-1:0] conv_val_reg;
    logic [ANGLE_W-1:0] operand_reg;
    logic [11:0]        bcd_work_reg;
    logic [BIT_W-1:0]   bit_cnt_reg;
    logic [11:0]        bcd_out_reg;
    logic               bcd_valid_reg;
    logic               trigger;
    logic [11:0]        bcd_adj;

    assign trigger = sel_ok && (pending_reg ||
                                sel_sync_reg != conv_sel_reg ||
                                sel_value != conv_val_reg);

    always_comb begin
        bcd_adj = bcd_work_reg;
        for (int n = 0; n < 3; n++)
            if (bcd_work_reg[4*n +: 4] >= 4'd5)
                bcd_adj[4*n +: 4] = bcd_work_reg[4*n +: 4] + 4'd3;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            pending_reg   <= 1'b1;
            conv_sel_reg  <= '0;
            conv_val_reg  <= '0;
            operand_reg   <= '0;
            bcd_work_reg  <= '0;
            bit_cnt_reg   <= '0;
            bcd_out_reg   <= '0;
            bcd_valid_reg <= 1'b0;
        end else if (trigger) begin
            state_reg     <= ST_SHIFT;
            pending_reg   <= 1'b0;
            conv_sel_reg  <= sel_sync_reg;
            conv_val_reg  <= sel_value;
            operand_reg   <= sel_value;
            bcd_work_reg  <= '0;
            bit_cnt_reg   <= '0;
            bcd_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_SHIFT: begin
                    bcd_work_reg <= (bcd_adj << 1) | {11'd0, operand_reg[ANGLE_W-1]};
                    operand_reg  <= operand_reg << 1;
                    bit_cnt_reg  <= bit_cnt_reg + 1'b1;
                    if (bit_cnt_reg == BIT_W'(ANGLE_W - 1))
                        state_reg <= ST_DONE;
                end
                ST_DONE: begin
                    bcd_out_reg   <= bcd_work_reg;
                    bcd_valid_reg <= 1'b1;
                    state_reg     <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bcd_out   = bcd_out_reg;
    assign bcd_valid = bcd_valid_reg;
    assign sel_err   = sel_err_reg;

endmodule

// File: tb/tb_angle_setpoint_ctrl.sv
// Testbench for angle_setpoint_ctrl: per-feature tasks with randomized
// stimulus checked against a behavioural model of the setpoints.
module tb_angle_setpoint_ctrl;

    localparam int NUM_CH    = 4;
    localparam int ANGLE_W   = 8;
    localparam int ANGLE_MAX = 180;
    localparam int ANGLE_INIT = 90;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      key_up_n = 1'b1;
    logic                      key_down_n = 1'b1;
    logic [NUM_CH-1:0]         ch_sel = 4'b0001;
    logic [NUM_CH*ANGLE_W-1:0] angle_flat;
    logic [11:0]               bcd_out;
    logic                      bcd_valid;
    logic                      sel_err;

    angle_setpoint_ctrl #(
        .NUM_CH(NUM_CH), .ANGLE_W(ANGLE_W), .ANGLE_MAX(ANGLE_MAX),
        .ANGLE_INIT(ANGLE_INIT), .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk), .rst(rst), .key_up_n(key_up_n), .key_down_n(key_down_n),
        .ch_sel(ch_sel), .angle_flat(angle_flat), .bcd_out(bcd_out),
        .bcd_valid(bcd_valid), .sel_err(sel_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int model [NUM_CH];
    logic [11:0] exp_bcd;

    function automatic logic [11:0] to_bcd(int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [NUM_CH*ANGLE_W-1:0] exp_flat();
        logic [NUM_CH*ANGLE_W-1:0] f;
        for (int i = 0; i < NUM_CH; i++) f[i*ANGLE_W +: ANGLE_W] = 8'(model[i]);
        return f;
    endfunction

    function automatic int sel_idx(logic [NUM_CH-1:0] s);
        for (int i = 0; i < NUM_CH; i++) if (s[i]) return i;
        return 0;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NUM_CH; i++) model[i] = ANGLE_INIT;
    endfunction

    function automatic void model_press(bit up, logic [NUM_CH-1:0] s);
        int k;
        if ($onehot(s)) begin
            k = sel_idx(s);
            if (up) model[k] = (model[k] + 1 > ANGLE_MAX) ? ANGLE_MAX : model[k] + 1;
            else    model[k] = (model[k] - 1 < 0) ? 0 : model[k] - 1;
        end
    endfunction

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_press(bit up, int hold);
        if (up) key_up_n = 1'b0; else key_down_n = 1'b0;
        tick(hold);
        key_up_n = 1'b1;
        key_down_n = 1'b1;
        tick(14);
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1; ch_sel = 4'b0001; key_up_n = 1'b1; key_down_n = 1'b1;
        model_reset();
        tick(3);
        checks++;
        if (angle_flat !== exp_flat()) begin
            fails++; $display("FAIL reset_angles got %h exp %h", angle_flat, exp_flat());
        end
        checks++;
        if (bcd_out !== 12'h000 || bcd_valid !== 1'b0 || sel_err !== 1'b0) begin
            fails++; $display("FAIL reset_outputs got bcd=%h valid=%b err=%b exp 000/0/0",
                              bcd_out, bcd_valid, sel_err);
        end
        rst = 1'b0;
        n = 0;
        while (bcd_valid !== 1'b1 && n < ANGLE_W + 6) begin tick(1); n++; end
        checks++;
        if (bcd_valid !== 1'b1) begin
            fails++; $display("FAIL reset_valid_latency got valid=%b after %0d cycles exp 1", bcd_valid, n);
        end
        checks++;
        if (bcd_out !== to_bcd(ANGLE_INIT)) begin
            fails++; $display("FAIL reset_bcd got %h exp %h", bcd_out, to_bcd(ANGLE_INIT));
        end
        $display("test_reset: bcd=%h valid=%b after %0d cycles", bcd_out, bcd_valid, n);
    endtask

    task automatic test_step_up();
        ch_sel = 4'b0100;
        tick(4);
        for (int p = 0; p < 3; p++) begin
            apply_press(1'b1, 10 + int'($urandom_range(0, 6)));
            model_press(1'b1, ch_sel);
            checks++;
            if (angle_flat !== exp_flat()) begin
                fails++; $display("FAIL step_up_angles got %h exp %h", angle_flat, exp_flat());
            end
            $display("test_step_up: press %0d angles=%h", p, angle_flat);
        end
        tick(6);
        checks++;
        if (bcd_valid !== 1'b1 || bcd_out !== to_bcd(model[2])) begin
            fails++; $display("FAIL step_up_bcd got %h/%b exp %h/1", bcd_out, bcd_valid, to_bcd(model[2]));
        end
        exp_bcd = to_bcd(model[2]);
    endtask

    task automatic test_bounce();
        for (int t = 0; t < 10; t++) begin
            key_up_n = ~key_up_n;
            tick(2);
        end
        key_up_n = 1'b0;
        tick(12);
        key_up_n = 1'b1;
        tick(14);
        model_press(1'b1, ch_sel);
        checks++;
        if (angle_flat !== exp_flat()) begin
            fails++; $display("FAIL bounce_angles got %h exp %h", angle_flat, exp_flat());
        end
        tick(6);
        exp_bcd = to_bcd(model[2]);
        checks++;
        if (bcd_out !== exp_bcd) begin
            fails++; $display("FAIL bounce_bcd got %h exp %h", bcd_out, exp_bcd);
        end
        $display("test_bounce: angles=%h bcd=%h", angle_flat, bcd_out);
    endtask

    task automatic test_sel_err();
        ch_sel = 4'b0110;
        tick(4);
        checks++;
        if (sel_err !== 1'b1) begin
            fails++; $display("FAIL sel_err_set got %b exp 1", sel_err);
        end
        apply_press(1'b1, 12);
        model_press(1'b1, ch_sel);
        checks++;
        if (angle_flat !== exp_flat()) begin
            fails++; $display("FAIL sel_err_angles got %h exp %h", angle_flat, exp_flat());
        end
        checks++;
        if (bcd_out !== exp_bcd || bcd_valid !== 1'b1) begin
            fails++; $display("FAIL sel_err_hold got %h/%b exp %h/1", bcd_out, bcd_valid, exp_bcd);
        end
        ch_sel = 4'b0010;
        tick(20);
        exp_bcd = to_bcd(model[1]);
        checks++;
        if (sel_err !== 1'b0 || bcd_valid !== 1'b1 || bcd_out !== exp_bcd) begin
            fails++; $display("FAIL sel_err_clear got err=%b bcd=%h valid=%b exp 0/%h/1",
                              sel_err, bcd_out, bcd_valid, exp_bcd);
        end
        $display("test_sel_err: err=%b bcd=%h", sel_err, bcd_out);
    endtask

    task automatic test_saturation();
        ch_sel = 4'b0001;
        tick(4);
        while (model[0] < ANGLE_MAX - 1) begin
            apply_press(1'b1, 10);
            model_press(1'b1, ch_sel);
        end
        for (int p = 0; p < 2; p++) begin
            apply_press(1'b1, 10);
            model_press(1'b1, ch_sel);
            checks++;
            if (angle_flat !== exp_flat()) begin
                fails++; $display("FAIL sat_up got %h exp %h", angle_flat, exp_flat());
            end
            $display("test_saturation: up ch0=%0d", angle_flat[7:0]);
        end
        ch_sel = 4'b0010;
        tick(4);
        while (model[1] > 1) begin
            apply_press(1'b0, 10);
            model_press(1'b0, ch_sel);
        end
        for (int p = 0; p < 2; p++) begin
            apply_press(1'b0, 10);
            model_press(1'b0, ch_sel);
            checks++;
            if (angle_flat !== exp_flat()) begin
                fails++; $display("FAIL sat_down got %h exp %h", angle_flat, exp_flat());
            end
            $display("test_saturation: down ch1=%0d", angle_flat[15:8]);
        end
    endtask

    task automatic test_abort();
        int n;
        logic [11:0] stale;
        bit saw_stale;
        ch_sel = 4'b0001;
        tick(20);
        key_down_n = 1'b0;
        n = 0;
        while (bcd_valid === 1'b1 && n < 30) begin tick(1); n++; end
        checks++;
        if (bcd_valid !== 1'b0) begin
            fails++; $display("FAIL abort_start got valid=%b exp 0", bcd_valid);
        end
        model_press(1'b0, 4'b0001);
        stale = to_bcd(model[0]);
        ch_sel = 4'b1000;
        key_down_n = 1'b1;
        saw_stale = 1'b0;
        n = 0;
        while (bcd_valid !== 1'b1 && n < 40) begin
            tick(1); n++;
            if (bcd_out === stale) saw_stale = 1'b1;
        end
        checks++;
        if (saw_stale !== 1'b0) begin
            fails++; $display("FAIL abort_stale got ch0 result %h on bcd_out exp never", stale);
        end
        exp_bcd = to_bcd(model[3]);
        checks++;
        if (bcd_valid !== 1'b1 || bcd_out !== exp_bcd) begin
            fails++; $display("FAIL abort_result got %h/%b exp %h/1", bcd_out, bcd_valid, exp_bcd);
        end
        tick(14);
        checks++;
        if (angle_flat !== exp_flat()) begin
            fails++; $display("FAIL abort_angles got %h exp %h", angle_flat, exp_flat());
        end
        $display("test_abort: bcd=%h after %0d cycles", bcd_out, n);
    endtask

    task automatic test_random();
        logic [NUM_CH-1:0] s;
        bit up;
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 5) == 0) s = 4'($urandom_range(0, 15));
            else                           s = 4'(1 << $urandom_range(0, NUM_CH - 1));
            up = 1'($urandom_range(0, 1));
            ch_sel = s;
            tick(4);
            apply_press(up, 10 + int'($urandom_range(0, 8)));
            model_press(up, s);
            tick(6);
            if ($onehot(s)) exp_bcd = to_bcd(model[sel_idx(s)]);
            checks++;
            if (angle_flat !== exp_flat()) begin
                fails++; $display("FAIL rand_angles got %h exp %h", angle_flat, exp_flat());
            end
            checks++;
            if (bcd_out !== exp_bcd || sel_err !== !$onehot(s)) begin
                fails++; $display("FAIL rand_bcd got %h err=%b exp %h err=%b",
                                  bcd_out, sel_err, exp_bcd, !$onehot(s));
            end
            $display("test_random: it=%0d sel=%b up=%0d angles=%h bcd=%h err=%b",
                     it, s, up, angle_flat, bcd_out, sel_err);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        ch_sel = 4'b0001;
        tick(20);
        ch_sel = 4'b0010;
        tick(5);
        rst = 1'b1;
        model_reset();
        tick(1);
        checks++;
        if (angle_flat !== exp_flat() || bcd_out !== 12'h000 || bcd_valid !== 1'b0 || sel_err !== 1'b0) begin
            fails++; $display("FAIL reset_mid_state got %h bcd=%h valid=%b err=%b exp %h/000/0/0",
                              angle_flat, bcd_out, bcd_valid, sel_err, exp_flat());
        end
        tick(1);
        rst = 1'b0;
        n = 0;
        while (bcd_valid !== 1'b1 && n < ANGLE_W + 6) begin tick(1); n++; end
        checks++;
        if (bcd_valid !== 1'b1 || bcd_out !== to_bcd(model[1])) begin
            fails++; $display("FAIL reset_mid_restart got %h/%b exp %h/1", bcd_out, bcd_valid, to_bcd(model[1]));
        end
        $display("test_reset_mid: bcd=%h after %0d cycles", bcd_out, n);
    endtask

    initial begin
        exp_bcd = '0;
        test_reset();
        test_step_up();
        test_bounce();
        test_sel_err();
        test_saturation();
        test_abort();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
